riscv_if: RTL

Instruction fetch stage for the RISC-V pipeline. It owns the program counter, issues one-at-a-time requests to instruction memory over a valid/ready request and response-valid interface, and registers each fetched word with its PC for the decode stage. Downstream bubbles, stalls, redirects from branch/jump resolution and misaligned targets are all handled here. Decode sees only a legal instruction word, with a NOP inserted whenever no valid fetch is available.

---
 rtl/riscv_if.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/riscv_if.sv
// Instruction fetch stage: owns the fetch PC, keeps one imem request in flight and
// hands registered (pc, instruction) pairs to decode, NOP-filling every bubble.
module riscv_if #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter logic [XLEN-1:0] NOP      = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] instruction,
    output logic [XLEN-1:0] pc,
    output logic            valid,
    output logic            exception
);

    typedef enum logic [2:0] {
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_DISCARD,
        S_HALT
    } state_t;

    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    state_t          state;
    logic            req_q;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] buf_word;
    logic            handshake;
    logic            pending;
    logic            misaligned;

    assign imem_req  = req_q;
    assign imem_addr = fetch_pc;
    assign handshake = req_q & imem_ready;
    assign misaligned = |redirect_pc[1:0];

    // A response is still owed to us after this edge: either accepted now, or
    // accepted earlier and not arriving in this cycle.
    always_comb begin
        pending = 1'b0;
        if (state == S_REQ)
            pending = handshake;
        else if (state == S_WAIT || state == S_DISCARD)
            pending = ~imem_rvalid;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= S_REQ;
            req_q       <= 1'b0;
            fetch_pc    <= RESET_PC;
            buf_word    <= NOP;
            instruction <= NOP;
            pc          <= RESET_PC;
            valid       <= 1'b0;
            exception   <= 1'b0;
        end else if (redirect) begin
            fetch_pc    <= redirect_pc;
            instruction <= NOP;
            valid       <= 1'b0;
            exception   <= misaligned;
            if (pending) begin
                state <= S_DISCARD;
                req_q <= 1'b0;
            end else if (misaligned) begin
                state <= S_HALT;
                req_q <= 1'b0;
            end else begin
                state <= S_REQ;
                req_q <= 1'b1;
            end
        end else begin
            // Bubble unless decode is stalled; the states below override with a real word.
            if (!stall) begin
                instruction <= NOP;
                valid       <= 1'b0;
            end
            case (state)
                S_REQ: begin
                    if (handshake) begin
                        state <= S_WAIT;
                        req_q <= 1'b0;
                    end else begin
                        req_q <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        if (stall) begin
                            buf_word <= imem_rdata;
                            state    <= S_HOLD;
                        end else begin
                            instruction <= imem_rdata;
                            pc          <= fetch_pc;
                            valid       <= 1'b1;
                            fetch_pc    <= fetch_pc + PC_STEP;
                            state       <= S_REQ;
                            req_q       <= 1'b1;
                        end
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        instruction <= buf_word;
                        pc          <= fetch_pc;
                        valid       <= 1'b1;
                        fetch_pc    <= fetch_pc + PC_STEP;
                        state       <= S_REQ;
                        req_q       <= 1'b1;
                    end
                end
                S_DISCARD: begin
                    if (imem_rvalid) begin
                        if (exception) begin
                            state <= S_HALT;
                        end else begin
                            state <= S_REQ;
                            req_q <= 1'b1;
                        end
                    end
                end
                S_HALT: begin
                    req_q <= 1'b0;
                end
                default: begin
                    state <= S_HALT;
                    req_q <= 1'b0;
                end
            endcase
        end
    end

endmodule
